// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline sequencing logic: trap codes,
// the controller state encoding and the fetch step.
package mips_pkg;

  // Exception code meaning "stall trap" at WB; it never halts the core.
  localparam logic [7:0] TRAP_STALL = 8'h01;

  // Sequential fetch increment in bytes.
  localparam int PC_STEP = 4;

  // Controller states.
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    SQUASH = 2'd1,
    HALTED = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/pipe_ctrl_valid_shifter.sv
// Per-stage valid shift register. Each stage either clears, holds its
// current value, or loads from the next younger stage (stage 0 loads fill_i).
// Clear wins over hold.
module valid_shifter #(
  parameter int STAGES = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] hold_i,
  input  logic [STAGES-1:0] clear_i,
  input  logic              fill_i,
  output logic [STAGES-1:0] valid_o
);

  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] valid_q;

  // Next valid vector: clear, hold or shift one stage towards WB.
  always_comb begin
    valid_d = valid_q;
    if (clear_i[0])     valid_d[0] = 1'b0;
    else if (hold_i[0]) valid_d[0] = valid_q[0];
    else                valid_d[0] = fill_i;
    for (int i = 1; i < STAGES; i++) begin
      if (clear_i[i])     valid_d[i] = 1'b0;
      else if (hold_i[i]) valid_d[i] = valid_q[i];
      else                valid_d[i] = valid_q[i-1];
    end
  end

  // Valid register, emptied by reset.
  always_ff @(posedge clk) begin
    if (!rst) valid_q <= '0;
    else      valid_q <= valid_d;
  end

  assign valid_o = valid_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: owns the fetch PC, the stage valid bits
// (through valid_shifter), stall/branch/exception handling with a
// RUN -> SQUASH -> HALTED flow, and the cycle / retired-instruction counters.
// Priority while running: exception > branch > stall > advance.
module pipe_ctrl
  import mips_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h00003000,
  parameter int              STAGES      = 5,
  parameter int              STALL_STAGE = 1,
  parameter int              BR_STAGE    = 2,
  parameter int              EXC_W       = 8,
  parameter int              CNT_W       = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_req,
  input  logic              br_enable,
  input  logic [XLEN-1:0]   br_target,
  input  logic [EXC_W-1:0]  wb_exception,
  input  logic              resume,
  input  logic [XLEN-1:0]   resume_pc,
  output logic [XLEN-1:0]   pc_if,
  output logic [STAGES-1:0] stage_valid,
  output logic [STAGES-1:0] stage_hold,
  output logic              halted,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  instret,
  output ctrl_state_e       dbg_state
);

  ctrl_state_e       state_q, state_d;
  logic [XLEN-1:0]   pc_q, pc_d;
  logic              halted_q, halted_d;
  logic [CNT_W-1:0]  cycle_q, cycle_d;
  logic [CNT_W-1:0]  instret_q, instret_d;

  logic [STAGES-1:0] hold_v;
  logic [STAGES-1:0] clear_v;
  logic              fill;
  logic              exc;
  logic              br_take;
  logic              stall_take;
  logic              retire;

  // Event qualification: each request only counts on a live stage in RUN.
  always_comb begin
    exc        = (state_q == RUN) && stage_valid[STAGES-1] &&
                 (wb_exception != '0) && (wb_exception != EXC_W'(TRAP_STALL));
    br_take    = (state_q == RUN) && !exc && br_enable && stage_valid[BR_STAGE];
    stall_take = (state_q == RUN) && !exc && !br_take && stall_req &&
                 stage_valid[STALL_STAGE];
    retire     = stage_valid[STAGES-1] && !exc;
  end

  // Next PC, state and valid-shifter controls.
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    halted_d = halted_q;
    hold_v   = '0;
    clear_v  = '0;
    fill     = 1'b0;
    case (state_q)
      RUN: begin
        if (exc) begin
          clear_v = '1;
          state_d = SQUASH;
        end else if (br_take) begin
          // Younger-than-branch instructions are wrong-path; the branch moves on.
          pc_d = br_target;
          for (int i = 1; i <= BR_STAGE; i++) clear_v[i] = 1'b1;
          fill = 1'b1;
        end else if (stall_take) begin
          for (int i = 0; i <= STALL_STAGE; i++) hold_v[i] = 1'b1;
          clear_v[STALL_STAGE+1] = 1'b1;
        end else begin
          pc_d = pc_q + XLEN'(PC_STEP);
          fill = 1'b1;
        end
      end
      SQUASH: begin
        clear_v  = '1;
        state_d  = HALTED;
        halted_d = 1'b1;
      end
      HALTED: begin
        if (resume) begin
          pc_d     = resume_pc;
          clear_v  = '1;
          clear_v[0] = 1'b0;
          fill     = 1'b1;
          state_d  = RUN;
          halted_d = 1'b0;
        end else begin
          clear_v = '1;
        end
      end
      default: begin
        clear_v = '1;
        state_d = RUN;
      end
    endcase
  end

  // Counters: cycles always advance, retirements only on a clean WB.
  always_comb begin
    cycle_d   = cycle_q + CNT_W'(1);
    instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
  end

  // Controller registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      halted_q  <= 1'b0;
      cycle_q   <= CNT_W'(1);
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      halted_q  <= halted_d;
      cycle_q   <= cycle_d;
      instret_q <= instret_d;
    end
  end

  valid_shifter #(.STAGES(STAGES)) u_valid (
    .clk     (clk),
    .rst     (rst),
    .hold_i  (hold_v),
    .clear_i (clear_v),
    .fill_i  (fill),
    .valid_o (stage_valid)
  );

  assign pc_if       = pc_q;
  assign stage_hold  = hold_v;
  assign halted      = halted_q;
  assign cycle_count = cycle_q;
  assign instret     = instret_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl with default parameters. A cycle model predicts the
// registered outputs; predictions are queued when inputs are driven and
// popped after the clock edge. Directed tasks add constant checks.
module tb_pipe_ctrl;
  import mips_pkg::*;

  localparam int W = 2 + 32 + 5 + 1 + 64 + 64;

  logic        clk;
  logic        rst;
  logic        stall_req;
  logic        br_enable;
  logic [31:0] br_target;
  logic [7:0]  wb_exception;
  logic        resume;
  logic [31:0] resume_pc;
  logic [31:0] pc_if;
  logic [4:0]  stage_valid;
  logic [4:0]  stage_hold;
  logic        halted;
  logic [63:0] cycle_count;
  logic [63:0] instret;
  ctrl_state_e dbg_state;

  int total;
  int bad;

  logic [W-1:0] exp_q[$];

  // model state: 0 RUN, 1 SQUASH, 2 HALTED
  logic [1:0]  m_st;
  logic [31:0] m_pc;
  logic [4:0]  m_v;
  logic        m_h;
  logic [63:0] m_cyc;
  logic [63:0] m_ins;

  pipe_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .stall_req    (stall_req),
    .br_enable    (br_enable),
    .br_target    (br_target),
    .wb_exception (wb_exception),
    .resume       (resume),
    .resume_pc    (resume_pc),
    .pc_if        (pc_if),
    .stage_valid  (stage_valid),
    .stage_hold   (stage_hold),
    .halted       (halted),
    .cycle_count  (cycle_count),
    .instret      (instret),
    .dbg_state    (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    stall_req    = 1'b0;
    br_enable    = 1'b0;
    br_target    = 32'h0;
    wb_exception = 8'h00;
    resume       = 1'b0;
    resume_pc    = 32'h0;
  endtask

  // Apply current inputs for one cycle: check stage_hold, predict, clock, compare.
  task automatic step(input string name);
    logic       exc;
    logic [4:0] exp_hold;
    logic [W-1:0] got, e;
    #1;
    exp_hold = 5'b00000;
    exc = (m_st == 2'd0) && m_v[4] && (wb_exception != 8'h00) && (wb_exception != 8'h01);
    if (rst && m_st == 2'd0 && !exc && !(br_enable && m_v[2]) && stall_req && m_v[1])
      exp_hold = 5'b00011;
    if (rst) begin
      total++;
      if (stage_hold !== exp_hold) begin
        bad++;
        $display("FAIL %s hold: got=%b exp=%b", name, stage_hold, exp_hold);
      end
    end
    if (!rst) begin
      m_st = 2'd0; m_pc = 32'h3000; m_v = 5'b0; m_h = 1'b0; m_cyc = 64'd1; m_ins = 64'd0;
    end else begin
      m_cyc = m_cyc + 64'd1;
      if (m_v[4] && !exc) m_ins = m_ins + 64'd1;
      case (m_st)
        2'd0: begin
          if (exc) begin
            m_v = 5'b0; m_st = 2'd1;
          end else if (br_enable && m_v[2]) begin
            m_pc = br_target;
            m_v  = {m_v[3], m_v[2], 1'b0, 1'b0, 1'b1};
          end else if (stall_req && m_v[1]) begin
            m_v  = {m_v[3], m_v[2], 1'b0, m_v[1], m_v[0]};
          end else begin
            m_pc = m_pc + 32'd4;
            m_v  = {m_v[3:0], 1'b1};
          end
        end
        2'd1: begin
          m_v = 5'b0; m_st = 2'd2; m_h = 1'b1;
        end
        default: begin
          if (resume) begin
            m_pc = resume_pc; m_v = 5'b00001; m_st = 2'd0; m_h = 1'b0;
          end
        end
      endcase
    end
    exp_q.push_back({m_st, m_pc, m_v, m_h, m_cyc, m_ins});
    @(posedge clk);
    #1;
    got = {dbg_state, pc_if, stage_valid, halted, cycle_count, instret};
    e = exp_q.pop_front();
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s outputs: got st=%0d pc=%h v=%b h=%b cyc=%0d ins=%0d exp st=%0d pc=%h v=%b h=%b cyc=%0d ins=%0d",
               name, got[W-1 -: 2], got[W-3 -: 32], got[133:129], got[128], got[127:64], got[63:0],
               e[W-1 -: 2], e[W-3 -: 32], e[133:129], e[128], e[127:64], e[63:0]);
    end
  endtask

  task automatic run(input int n, input string name);
    idle_inputs();
    for (int i = 0; i < n; i++) step(name);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    step("reset");
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (pc_if !== 32'h3000 || stage_valid !== 5'b0 || halted !== 1'b0 ||
        cycle_count !== 64'd1 || instret !== 64'd0) begin
      bad++;
      $display("FAIL reset_const: pc=%h v=%b h=%b cyc=%0d ins=%0d", pc_if, stage_valid, halted, cycle_count, instret);
    end
  endtask

  task automatic test_free_run();
    run(6, "free_run");
    total++;
    if (pc_if !== 32'h3018 || stage_valid !== 5'b11111 || instret !== 64'd1) begin
      bad++;
      $display("FAIL free_run_const: pc=%h (exp 3018) v=%b ins=%0d (exp 1)", pc_if, stage_valid, instret);
    end
  endtask

  task automatic test_stall();
    logic [31:0] pc0;
    pc0 = pc_if;
    idle_inputs();
    stall_req = 1'b1;
    step("stall0");
    step("stall1");
    total++;
    if (pc_if !== pc0) begin
      bad++;
      $display("FAIL stall_pc: got=%h exp=%h", pc_if, pc0);
    end
    run(5, "after_stall");
  endtask

  task automatic test_branch();
    idle_inputs();
    br_enable = 1'b1; br_target = 32'h3400;
    step("branch");
    total++;
    if (pc_if !== 32'h3400 || stage_valid[2:0] !== 3'b001) begin
      bad++;
      $display("FAIL branch_const: pc=%h exp=3400 v=%b", pc_if, stage_valid);
    end
    run(3, "after_branch");
    idle_inputs();
    br_enable = 1'b1; br_target = 32'h3400; stall_req = 1'b1;
    step("branch_stall");
    total++;
    if (pc_if !== 32'h3400 || stage_valid[2:0] !== 3'b001) begin
      bad++;
      $display("FAIL branch_stall_const: pc=%h exp=3400 v=%b", pc_if, stage_valid);
    end
    // branch request on an empty BR stage is ignored
    br_enable = 1'b1; br_target = 32'h5000; stall_req = 1'b0;
    step("branch_invalid");
    run(4, "after_branch2");
  endtask

  task automatic test_exception();
    logic [63:0] ins0;
    idle_inputs();
    wb_exception = 8'h01;
    step("trap_stall");
    run(2, "after_trap");
    total++;
    if (halted !== 1'b0) begin
      bad++;
      $display("FAIL trap_no_halt: halted=%b exp=0", halted);
    end
    ins0 = instret;
    wb_exception = 8'h04;
    step("exc");
    total++;
    if (stage_valid !== 5'b0 || halted !== 1'b0) begin
      bad++;
      $display("FAIL exc_squash: v=%b h=%b exp v=00000 h=0", stage_valid, halted);
    end
    idle_inputs();
    step("squash");
    total++;
    if (halted !== 1'b1 || instret !== ins0) begin
      bad++;
      $display("FAIL exc_halt: h=%b ins=%0d exp h=1 ins=%0d", halted, instret, ins0);
    end
    stall_req = 1'b1; br_enable = 1'b1; br_target = 32'h7000;
    step("halted_noise");
    run(3, "halted_idle");
  endtask

  task automatic test_resume();
    idle_inputs();
    resume = 1'b1; resume_pc = 32'h3100;
    step("resume");
    total++;
    if (pc_if !== 32'h3100 || stage_valid !== 5'b00001 || halted !== 1'b0) begin
      bad++;
      $display("FAIL resume_const: pc=%h v=%b h=%b exp 3100 00001 0", pc_if, stage_valid, halted);
    end
    resume = 1'b1; resume_pc = 32'h9000;
    step("resume_in_run");
    total++;
    if (pc_if !== 32'h3104) begin
      bad++;
      $display("FAIL resume_ignored: pc=%h exp=3104", pc_if);
    end
    run(5, "after_resume");
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    stall_req = 1'b1;
    step("pre_reset_stall");
    do_reset();
    total++;
    if (pc_if !== 32'h3000 || stage_valid !== 5'b0 || cycle_count !== 64'd1) begin
      bad++;
      $display("FAIL reset_mid_stall: pc=%h v=%b cyc=%0d", pc_if, stage_valid, cycle_count);
    end
    run(6, "refill");
    wb_exception = 8'h22;
    step("exc2");
    idle_inputs();
    do_reset();
    run(3, "post_squash_reset");
    total++;
    if (halted !== 1'b0 || pc_if !== 32'h300c) begin
      bad++;
      $display("FAIL reset_mid_squash: h=%b pc=%h exp h=0 pc=300c", halted, pc_if);
    end
  endtask

  task automatic test_wrap();
    idle_inputs();
    br_enable = 1'b1; br_target = 32'hFFFF_FFFC;
    step("br_to_top");
    idle_inputs();
    step("wrap");
    total++;
    if (pc_if !== 32'h0000_0000) begin
      bad++;
      $display("FAIL wrap: pc=%h exp=00000000", pc_if);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      idle_inputs();
      stall_req    = ($urandom_range(0, 3) == 0);
      br_enable    = ($urandom_range(0, 4) == 0);
      br_target    = {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h4000;
      wb_exception = ($urandom_range(0, 19) == 0) ? 8'($urandom_range(0, 255)) : 8'h00;
      resume       = ($urandom_range(0, 2) == 0);
      resume_pc    = 32'h3100 + {$urandom_range(0, 255), 2'b00};
      rst          = ($urandom_range(0, 99) != 0);
      step("random");
      rst = 1'b1;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    m_st = 2'd0; m_pc = 32'h0; m_v = 5'b0; m_h = 1'b0; m_cyc = 64'd0; m_ins = 64'd0;
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_free_run();
    test_stall();
    test_branch();
    test_exception();
    test_resume();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Parametrised pipeline sequencing controller for the MIPS core. It owns the fetch PC, the per-stage valid bits, stall bubbles, branch squash and exception halt/resume. It also keeps the cycle and retired-instruction counters. It sits beside the datapath and drives PC and stage-valid signals into IF/ID/EX/MEM/WB for any depth and branch-resolve stage.

Parameters:
XLEN, 32, PC and branch-target width
RESET_PC, 32'h00003000, PC loaded at reset
STAGES, 5, pipeline depth (>=3); stage 0 = IF, stage STAGES-1 = WB
STALL_STAGE, 1, stage raising the load-use stall (holds itself and younger stages)
BR_STAGE, 2, stage resolving branches (STALL_STAGE < BR_STAGE < STAGES-1)
EXC_W, 8, exception code width
CNT_W, 64, counter width

Ports:
clk  in  1  clock
rst  in  1  reset; synchronous, active-low
stall_req  in  1  load-use hazard from STALL_STAGE
br_enable  in  1  taken branch resolved in BR_STAGE (qualified internally by valid[BR_STAGE])
br_target  in  XLEN  redirect address
wb_exception  in  EXC_W  exception code arriving at WB
resume  in  1  debug resume pulse, honoured only in HALTED
resume_pc  in  XLEN  PC to restart from
pc_if  out  XLEN  current fetch PC
stage_valid  out  STAGES  bit i = stage i holds a live instruction
stage_hold  out  STAGES  bit i = stage i pipeline register must not load this cycle
halted  out  1  core halted
cycle_count  out  CNT_W  cycles since reset
instret  out  CNT_W  retired instructions

Behaviour:
- Reset (rst==0 at posedge):
  - pc_if=RESET_PC, stage_valid=0, state=RUN, halted=0, cycle_count=1, instret=0.
  - Reset mid-operation discards everything in flight, including a pending halt.
- FSM states: RUN, SQUASH, HALTED.
- "exc": wb_exception != 0 and != TRAP_STALL, with stage_valid[STAGES-1]=1.
- RUN priority, highest first: exc > branch > stall > advance.
  - exc: all stage_valid cleared, pc held, state goes to SQUASH. Faulting instruction is not counted in instret.
  - branch (br_enable && stage_valid[BR_STAGE]):
    - pc_if<=br_target.
    - stage_valid[1..BR_STAGE]<=0, stage_valid[0]<=1.
    - Stages > BR_STAGE shift normally; the branch itself advances.
    - A simultaneous stall_req is ignored because the stalled instruction is squashed.
  - stall (stall_req && stage_valid[STALL_STAGE]):
    - pc_if held; stage_hold[0..STALL_STAGE]=1.
    - stage_valid[STALL_STAGE+1]<=0 (bubble); older stages shift.
    - Stall persists while stall_req stays high; no bound.
  - advance: pc_if<=pc_if+4, wrapping modulo 2^XLEN. stage_valid[i]<=stage_valid[i-1], stage_valid[0]<=1.
- SQUASH: one cycle, stage_valid stays 0, then HALTED.
- HALTED:
  - halted=1; pc, valid and instret are frozen; cycle_count keeps counting.
  - resume: pc_if<=resume_pc, stage_valid<=1 (IF only), state goes to RUN, halted<=0 next cycle.
  - resume outside HALTED is ignored.
- instret increments in any cycle where stage_valid[STAGES-1]=1 and not exc.
- cycle_count increments every non-reset cycle; both counters wrap silently.
- stage_hold is combinational from current state and inputs; all other outputs are registered.
- A stall_req or br_enable on an invalid stage is ignored.
- All latencies:
  - branch: redirected fetch appears on pc_if one cycle after br_enable.
  - exc: halted rises two cycles after exc (SQUASH then HALTED).

Decomposition:
- Shared package mips_pkg: TRAP_STALL code (EXC_W'h01, replacing the global define), FSM state enum {RUN,SQUASH,HALTED}, PC_STEP=4.
- One natural sub-module, valid_shifter: parametrised STAGES-bit valid shift register with per-stage hold/clear inputs.
- pipe_ctrl keeps the PC, FSM and counters.

Test Plan:
- Reset then 6 free-running cycles -> pc_if 0x3000,0x3004..0x3018. stage_valid 00001→00011→…→11111. instret=1 at cycle 6.
- stall_req high 2 cycles while stage_valid=11111 and pc_if=0x3010 -> pc_if held 0x3010 both cycles. stage_hold[1:0]=11. Bubbles at stage 2. instret skips 2 retirements, 3 cycles later.
- br_enable with br_target=0x3400 at pc_if=0x3010 -> next pc_if=0x3400, stage_valid[2:1]=00, stage_valid[0]=1. Same with stall_req=1 -> identical result.
- wb_exception=8'h04 with WB valid -> stage_valid=0 next cycle, halted=1 two cycles later. instret unchanged, cycle_count still counting. wb_exception=TRAP_STALL -> no halt.
- In HALTED, resume with resume_pc=0x3100 -> pc_if=0x3100, stage_valid=00001, halted=0. resume pulse in RUN -> ignored.
- rst low mid-stall and mid-SQUASH -> next cycle pc_if=0x3000, valid=0, halted=0, cycle_count=1. pc_if=0xFFFFFFFC advance -> 0x00000000.
